// File: rtl/rr_arb_mux__pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_mux__pkg
// Shared helpers for the round-robin arbitrating multiplexer.
//   wrap_inc : increment an index modulo an arbitrary (non power-of-two)
//              channel count; used to advance the round-robin pointer.
// ---------------------------------------------------------------------------
package rr_arb_mux__pkg;

  // Next index after idx in a ring of n entries. The wrap is at n, not at a
  // power of two, so a 3-channel ring goes 0,1,2,0 and never visits 3.
  function automatic int unsigned wrap_inc(input int unsigned idx,
                                           input int unsigned n);
    int unsigned res;
    if (idx >= n - 32'd1) begin
      res = 32'd0;
    end else begin
      res = idx + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arb_mux__grant.sv
// ---------------------------------------------------------------------------
// rr_grant_
// Combinational round-robin grant finder.
//   valid     : per-channel request vector
//   ptr       : highest-priority channel index (0..N_INS-1)
//   grant     : one-hot grant (all zero when nothing requests)
//   grant_idx : encoded index of the granted channel
//   found     : some channel was granted
// The request vector is duplicated to 2*N_INS bits and everything below ptr
// is masked off; the lowest remaining set bit is the winner. Bits in the
// upper copy stand for the wrapped-around channels, so the search order is
// ptr..N_INS-1 followed by 0..ptr-1 with no modulo-2^k aliasing.
// ---------------------------------------------------------------------------
module rr_grant_ #(
  parameter  int unsigned N_INS     = 4,
  localparam int unsigned SEL_WIDTH = $clog2(N_INS)
) (
  input  logic [N_INS-1:0]     valid,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [N_INS-1:0]     grant,
  output logic [SEL_WIDTH-1:0] grant_idx,
  output logic                 found
);

  logic [2*N_INS-1:0] dbl_s;
  logic [2*N_INS-1:0] masked_s;

  // Masked double-width priority search followed by one-hot decode.
  always_comb begin
    dbl_s     = {valid, valid};
    masked_s  = {(2*N_INS){1'b0}};
    grant     = {N_INS{1'b0}};
    grant_idx = {SEL_WIDTH{1'b0}};
    found     = 1'b0;

    for (int i = 0; i < 2 * int'(N_INS); i++) begin
      if (i >= int'(ptr)) begin
        masked_s[i] = dbl_s[i];
      end else begin
        masked_s[i] = 1'b0;
      end
    end

    for (int i = 0; i < 2 * int'(N_INS); i++) begin
      if (masked_s[i] && !found) begin
        found = 1'b1;
        if (i >= int'(N_INS)) begin
          grant_idx = SEL_WIDTH'(i - int'(N_INS));
        end else begin
          grant_idx = SEL_WIDTH'(i);
        end
      end else begin
        found = found;
      end
    end

    for (int i = 0; i < int'(N_INS); i++) begin
      grant[i] = found && (grant_idx == SEL_WIDTH'(i));
    end
  end

endmodule

// File: rtl/rr_arb_mux__mux.sv
// ---------------------------------------------------------------------------
// rr_mux_
// N-input AND-OR data multiplexer selected by an encoded index.
//   ins : per-channel data
//   sel : encoded channel index
//   y   : selected data (zero when sel matches no channel)
// ---------------------------------------------------------------------------
module rr_mux_ #(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned N_INS     = 4,
  localparam int unsigned SEL_WIDTH = $clog2(N_INS)
) (
  input  logic [N_INS-1:0][WIDTH-1:0] ins,
  input  logic [SEL_WIDTH-1:0]        sel,
  output logic [WIDTH-1:0]            y
);

  // Decode sel per channel and OR the gated data words together.
  always_comb begin
    y = {WIDTH{1'b0}};
    for (int i = 0; i < int'(N_INS); i++) begin
      y = y | (ins[i] & {WIDTH{sel == SEL_WIDTH'(i)}});
    end
  end

endmodule

// File: rtl/rr_arb_mux_.sv
// ---------------------------------------------------------------------------
// rr_arb_mux_
// Registered N-input round-robin arbitrating multiplexer with valid/ready on
// every input channel and on the single output.
//   clk       : clock, all state on rising edge
//   rst_aN    : asynchronous active-low reset
//   ins_valid : per-channel request
//   ins       : per-channel data
//   ins_ready : per-channel accept, at most one bit high
//   out_valid : output register holds an entry
//   out_ready : consumer accepts the entry
//   out       : registered data
//   out_sel   : index of the channel that produced out
// The grant depends only on ins_valid and the priority pointer; the output
// register state only gates whether the granted channel is told ready, so
// there is no loop from ins_ready back into the arbiter.
// ---------------------------------------------------------------------------
module rr_arb_mux_
  import rr_arb_mux__pkg::*;
#(
  parameter  int unsigned WIDTH     = 32,
  parameter  int unsigned N_INS     = 4,
  localparam int unsigned SEL_WIDTH = $clog2(N_INS)
) (
  input  logic                        clk,
  input  logic                        rst_aN,
  input  logic [N_INS-1:0]            ins_valid,
  input  logic [N_INS-1:0][WIDTH-1:0] ins,
  output logic [N_INS-1:0]            ins_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out,
  output logic [SEL_WIDTH-1:0]        out_sel
);

  logic [SEL_WIDTH-1:0] ptr_r;
  logic                 out_valid_r;
  logic [WIDTH-1:0]     out_r;
  logic [SEL_WIDTH-1:0] out_sel_r;

  logic [N_INS-1:0]     grant_s;
  logic [SEL_WIDTH-1:0] grant_idx_s;
  logic                 found_s;
  logic                 can_load_s;
  logic                 xfer_s;
  logic [WIDTH-1:0]     mux_out_s;
  logic [SEL_WIDTH-1:0] ptr_nxt_s;

  rr_grant_ #(
    .N_INS (N_INS)
  ) u_grant (
    .valid     (ins_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .found     (found_s)
  );

  rr_mux_ #(
    .WIDTH (WIDTH),
    .N_INS (N_INS)
  ) u_mux (
    .ins (ins),
    .sel (grant_idx_s),
    .y   (mux_out_s)
  );

  // The register can take a new entry when empty or being drained this cycle.
  assign can_load_s = ~out_valid_r | out_ready;
  assign ins_ready  = grant_s & {N_INS{can_load_s}};
  assign xfer_s     = found_s & can_load_s;
  // Priority moves to the channel just after the winner.
  assign ptr_nxt_s  = SEL_WIDTH'(wrap_inc(32'(grant_idx_s), N_INS));

  // Output register and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_aN) begin
    if (!rst_aN) begin
      out_valid_r <= 1'b0;
      out_r       <= {WIDTH{1'b0}};
      out_sel_r   <= {SEL_WIDTH{1'b0}};
      ptr_r       <= {SEL_WIDTH{1'b0}};
    end else begin
      if (xfer_s) begin
        // Covers both load-into-empty and drain-and-replace in one cycle.
        out_valid_r <= 1'b1;
        out_r       <= mux_out_s;
        out_sel_r   <= grant_idx_s;
        ptr_r       <= ptr_nxt_s;
      end else if (out_ready) begin
        // Drain only; data and index keep their last value.
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_arb_mux_.sv
// ---------------------------------------------------------------------------
// tb_rr_arb_mux_
// Bench for rr_arb_mux_: a 4-channel instance driven from a vector table
// with a data scoreboard, plus a 3-channel instance for ring wrap-around.
// ---------------------------------------------------------------------------
module tb_rr_arb_mux_;

  logic clk;
  logic rst_aN;

  logic [3:0]       ins_valid4;
  logic [3:0][31:0] ins4;
  logic [3:0]       ins_ready4;
  logic             out_valid4;
  logic             out_ready4;
  logic [31:0]      out4;
  logic [1:0]       out_sel4;

  logic [2:0]       ins_valid3;
  logic [2:0][31:0] ins3;
  logic [2:0]       ins_ready3;
  logic             out_valid3;
  logic             out_ready3;
  logic [31:0]      out3;
  logic [1:0]       out_sel3;

  int total;
  int bad;

  rr_arb_mux_ #(.WIDTH(32), .N_INS(4)) dut4 (
    .clk       (clk),
    .rst_aN    (rst_aN),
    .ins_valid (ins_valid4),
    .ins       (ins4),
    .ins_ready (ins_ready4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out       (out4),
    .out_sel   (out_sel4)
  );

  rr_arb_mux_ #(.WIDTH(32), .N_INS(3)) dut3 (
    .clk       (clk),
    .rst_aN    (rst_aN),
    .ins_valid (ins_valid3),
    .ins       (ins3),
    .ins_ready (ins_ready3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out       (out3),
    .out_sel   (out_sel3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] ready;  // expected ins_ready before the edge
    logic       ov;     // expected out_valid after the edge
    logic [1:0] sel;    // expected out_sel after the edge
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
  } sb_t;

  vec_t tab[22];
  sb_t  sbq[$];

  function automatic vec_t mk(input logic [3:0] v, input logic o,
                              input logic [3:0] rd, input logic ov,
                              input logic [1:0] s);
    vec_t t;
    t.valid = v;
    t.ordy  = o;
    t.ready = rd;
    t.ov    = ov;
    t.sel   = s;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    logic prev_ov;
    int   g;
    sb_t  e;

    total = 0;
    bad   = 0;

    // Fairness 0,1,2,3,0,1 from ptr=0.
    tab[0]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    tab[1]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    tab[2]  = mk(4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2);
    tab[3]  = mk(4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3);
    tab[4]  = mk(4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
    tab[5]  = mk(4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
    // Bring ptr to 3, then skip and wrap with 0101.
    tab[6]  = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    tab[7]  = mk(4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0);
    tab[8]  = mk(4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2);
    // Five cycles of backpressure with channel 1 waiting.
    tab[9]  = mk(4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2);
    tab[10] = mk(4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2);
    tab[11] = mk(4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2);
    tab[12] = mk(4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2);
    tab[13] = mk(4'b0010, 1'b0, 4'b0000, 1'b1, 2'd2);
    tab[14] = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
    // Drain, idle, then mixed traffic from ptr=2.
    tab[15] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);
    tab[16] = mk(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd1);
    tab[17] = mk(4'b1011, 1'b0, 4'b1000, 1'b1, 2'd3);
    tab[18] = mk(4'b0011, 1'b0, 4'b0000, 1'b1, 2'd3);
    tab[19] = mk(4'b0011, 1'b1, 4'b0001, 1'b1, 2'd0);
    tab[20] = mk(4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
    tab[21] = mk(4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);

    for (int i = 0; i < 4; i++) ins4[i] = 32'(i + 1) << 28;
    for (int i = 0; i < 3; i++) ins3[i] = 32'h3000_0000 + 32'(i);
    ins_valid3 = 3'b000;
    out_ready3 = 1'b1;

    // Reset held with all channels requesting.
    rst_aN     = 1'b0;
    ins_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 32'(out_valid4), 32'd0);
    check("rst out", out4, 32'd0);
    check("rst out_sel", 32'(out_sel4), 32'd0);
    check("rst ins_ready", 32'(ins_ready4), 32'b0001);
    ins_valid4 = 4'b0000;
    rst_aN     = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors with data scoreboard.
    prev_ov = 1'b0;
    for (int r = 0; r < 22; r++) begin
      ins_valid4 = tab[r].valid;
      out_ready4 = tab[r].ordy;
      @(negedge clk);
      check($sformatf("row%0d ins_ready", r), 32'(ins_ready4), 32'(tab[r].ready));
      if (prev_ov) begin
        if (sbq.size() == 0) begin
          check($sformatf("row%0d sb underflow", r), 32'd1, 32'd0);
        end else begin
          check($sformatf("row%0d out", r), out4, sbq[0].data);
          check($sformatf("row%0d sb sel", r), 32'(out_sel4), 32'(sbq[0].sel));
          if (tab[r].ordy) void'(sbq.pop_front());
        end
      end
      g = -1;
      for (int i = 0; i < 4; i++) if (tab[r].ready[i] && tab[r].valid[i]) g = i;
      if (g >= 0) begin
        e.data = ins4[g];
        e.sel  = 2'(g);
        sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", r), 32'(out_valid4), 32'(tab[r].ov));
      check($sformatf("row%0d out_sel", r), 32'(out_sel4), 32'(tab[r].sel));
      prev_ov = tab[r].ov;
      if (g >= 0) ins4[g] = ins4[g] + 32'd1;
    end
    check("sb drained", 32'(sbq.size()), 32'd0);

    // Reset mid-stream: load channel 2, then reset between edges.
    ins_valid4 = 4'b0100;
    out_ready4 = 1'b0;
    @(posedge clk);
    #1;
    check("mid load out_valid", 32'(out_valid4), 32'd1);
    check("mid load out_sel", 32'(out_sel4), 32'd2);
    check("mid load out", out4, ins4[2]);
    #1;
    rst_aN     = 1'b0;
    ins_valid4 = 4'b1111;
    #1;
    check("mid rst out_valid", 32'(out_valid4), 32'd0);
    check("mid rst out", out4, 32'd0);
    check("mid rst out_sel", 32'(out_sel4), 32'd0);
    check("mid rst ins_ready", 32'(ins_ready4), 32'b0001);
    sbq.delete();
    ins_valid4 = 4'b0000;
    @(negedge clk);
    rst_aN = 1'b1;
    @(posedge clk);
    #1;
    ins_valid4 = 4'b1111;
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    check("post rst out_valid", 32'(out_valid4), 32'd1);
    check("post rst out_sel", 32'(out_sel4), 32'd0);
    check("post rst out", out4, ins4[0]);
    ins_valid4 = 4'b0000;

    // Three-channel ring: only channel 2 requests, pointer must wrap to 0.
    ins_valid3 = 3'b100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("n3 c%0d ins_ready", k), 32'(ins_ready3), 32'b100);
      @(posedge clk);
      #1;
      check($sformatf("n3 c%0d out_valid", k), 32'(out_valid3), 32'd1);
      check($sformatf("n3 c%0d out_sel", k), 32'(out_sel3), 32'd2);
      check($sformatf("n3 c%0d out", k), out3, 32'h3000_0002);
    end
    ins_valid3 = 3'b011;
    @(negedge clk);
    check("n3 wrap ins_ready", 32'(ins_ready3), 32'b001);
    @(posedge clk);
    #1;
    check("n3 wrap out_sel", 32'(out_sel3), 32'd0);
    check("n3 wrap out", out3, 32'h3000_0000);
    ins_valid3 = 3'b000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
